mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk samples on the rising edge; reset clears state immediately, with no clock edge needed.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- reset  in  1  async active-high reset
- i_mem_read  in  1  load request from EX/MEM
- i_mem_write  in  1  store request from EX/MEM
- i_mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- i_mem_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- i_addr  in  32  byte address (ALU result)
- i_write_data  in  32  store data
- o_dmem_req  out  1  memory request
- o_dmem_we  out  1  memory write strobe
- o_dmem_addr  out  32  word address ({i_addr[31:2],2'b00})
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_be  out  4  byte enables
- i_dmem_ready  in  1  memory completion
- i_dmem_rdata  in  32  memory read word
- o_stall  out  1  freeze IF..EX/MEM
- o_mem_read_data  out  32  extended load result to MEM/WB
- o_misaligned  out  1  alignment fault
- o_bus_error  out  1  timeout fault
REQ-003 Parameter TIMEOUT SHALL be a cycle count, default 255, meaning the BUSY cycles allowed before the block forces completion.

Function
REQ-004 An access SHALL be pending when (i_mem_read|i_mem_write) & ~o_misaligned; when both strobes are high, the write SHALL take priority.
REQ-005 o_misaligned SHALL be combinational and high when a read or write is present and either size=half with addr[0]=1 or size=word/11 with addr[1:0]!=0; a misaligned access SHALL issue no request and SHALL NOT stall.
REQ-006 FSM states SHALL be IDLE, BUSY and DONE.
- IDLE: a pending access registers addr, we, be and wdata, then goes to BUSY.
- BUSY: on i_dmem_ready go to DONE; at timeout go to DONE.
- DONE: always go to IDLE.
REQ-007 o_dmem_req SHALL be high exactly while in BUSY; o_dmem_addr, o_dmem_we, o_dmem_be and o_dmem_wdata SHALL be registered and stable throughout BUSY.
REQ-008 o_stall SHALL be combinational and equal pending & (state!=DONE).
- The pipeline advances in the DONE cycle.
- Minimum access latency is 3 cycles (IDLE, BUSY, DONE) with 2 stall cycles.
REQ-009 Store byte enables SHALL be:
- byte: 4'b0001<<addr[1:0]
- half: 4'b0011 when addr[1]=0, else 4'b1100
- word: 4'b1111
REQ-010 Store data SHALL be replicated: byte as {4{wd[7:0]}}, half as {2{wd[15:0]}}, word unchanged.
REQ-011 A load SHALL select its lane from i_dmem_rdata by addr[1:0] (byte) or addr[1] (half), extend it per i_mem_unsigned, and register the result into o_mem_read_data on the BUSY->DONE edge when i_dmem_ready=1.
REQ-012 o_mem_read_data SHALL hold its value until the next completed load; stores and misaligned accesses SHALL NOT change it.
REQ-013 A BUSY cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle without ready; when it reaches TIMEOUT the FSM goes to DONE, o_bus_error is high for the DONE cycle, and o_mem_read_data is set to 0 for a load.
REQ-014 i_dmem_ready SHALL be ignored outside BUSY.
REQ-015 i_dmem_ready in the same cycle as the timeout SHALL count as normal completion, with no error.

Reset
REQ-016 On reset the state SHALL be IDLE and the counter 0, and all outputs SHALL be 0: o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be, o_mem_read_data, o_bus_error.
REQ-017 Reset during BUSY SHALL drop o_dmem_req immediately (asynchronously) and abandon the access; a ready arriving after reset SHALL be ignored.

Verification
REQ-018 Word load: addr=0x100, rdata=0xDEADBEEF, ready in the 1st BUSY cycle -> req for 1 cycle, stall 2 cycles, o_mem_read_data=0xDEADBEEF in DONE.
REQ-019 Signed byte load: addr=0x103, rdata=0x80FF_FFFF -> 0xFFFFFF80; same access with i_mem_unsigned=1 -> 0x00000080.
REQ-020 Half store: addr=0x202, wd=0x1234ABCD -> be=1100, wdata=0xABCDABCD, we=1, o_dmem_addr=0x200.
REQ-021 Misaligned word load at 0x101 -> o_misaligned=1, req never high, stall=0, o_mem_read_data unchanged.
REQ-022 Ready never asserted -> DONE after TIMEOUT BUSY cycles, o_bus_error pulses 1 cycle, load data=0; a separate run with reset asserted mid-BUSY -> req=0 immediately, state IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access unit: aligns stores, extracts loads and stalls the pipeline
// until the memory completes or a bus timeout forces completion.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_mem_size,
  input  logic        i_mem_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic [31:0] o_mem_read_data,
  output logic        o_misaligned,
  output logic        o_bus_error
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] busy_cnt;
  logic [1:0]       ld_lane;
  logic [1:0]       ld_size;
  logic             ld_unsigned;
  logic             pending;
  logic [3:0]       be_next;
  logic [31:0]      wdata_next;

  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  always_comb begin
    o_misaligned = 1'b0;
    if (i_mem_read | i_mem_write) begin
      if (i_mem_size == 2'b01)
        o_misaligned = i_addr[0];
      else if (i_mem_size[1])
        o_misaligned = (i_addr[1:0] != 2'b00);
    end
  end

  assign pending = (i_mem_read | i_mem_write) & ~o_misaligned;
  // The pipeline is released in DONE so the next instruction enters in IDLE.
  assign o_stall = pending & (state != DONE);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = i_write_data;
    case (i_mem_size)
      2'b00: begin
        be_next    = 4'b0001 << i_addr[1:0];
        wdata_next = {4{i_write_data[7:0]}};
      end
      2'b01: begin
        be_next    = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{i_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      busy_cnt        <= '0;
      o_dmem_req      <= 1'b0;
      o_dmem_we       <= 1'b0;
      o_dmem_addr     <= '0;
      o_dmem_wdata    <= '0;
      o_dmem_be       <= '0;
      o_mem_read_data <= '0;
      o_bus_error     <= 1'b0;
      ld_lane         <= '0;
      ld_size         <= '0;
      ld_unsigned     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_bus_error <= 1'b0;
          if (pending) begin
            o_dmem_addr  <= {i_addr[31:2], 2'b00};
            o_dmem_we    <= i_mem_write;
            o_dmem_be    <= be_next;
            o_dmem_wdata <= wdata_next;
            ld_lane      <= i_addr[1:0];
            ld_size      <= i_mem_size;
            ld_unsigned  <= i_mem_unsigned;
            o_dmem_req   <= 1'b1;
            busy_cnt     <= '0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // Ready wins over a coinciding timeout.
          if (i_dmem_ready) begin
            o_dmem_req <= 1'b0;
            state      <= DONE;
            if (!o_dmem_we)
              o_mem_read_data <= load_extend(i_dmem_rdata, ld_lane, ld_size, ld_unsigned);
          end else if (busy_cnt == CNT_W'(TIMEOUT - 1)) begin
            o_dmem_req  <= 1'b0;
            o_bus_error <= 1'b1;
            state       <= DONE;
            if (!o_dmem_we)
              o_mem_read_data <= '0;
          end else begin
            busy_cnt <= busy_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          o_bus_error <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, randomized accesses against
// an arithmetic reference model, timeout and asynchronous reset sequences.
module tb_mem_access_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_mem_read, i_mem_write, i_mem_unsigned;
  logic [1:0]  i_mem_size;
  logic [31:0] i_addr, i_write_data;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ready;
  logic [31:0] i_dmem_rdata;
  logic        o_stall;
  logic [31:0] o_mem_read_data;
  logic        o_misaligned, o_bus_error;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_size(i_mem_size), .i_mem_unsigned(i_mem_unsigned),
    .i_addr(i_addr), .i_write_data(i_write_data),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_be(o_dmem_be), .i_dmem_ready(i_dmem_ready),
    .i_dmem_rdata(i_dmem_rdata), .o_stall(o_stall),
    .o_mem_read_data(o_mem_read_data), .o_misaligned(o_misaligned),
    .o_bus_error(o_bus_error)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          delay;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdv;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_rd;
  vec_t        tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on byte offsets.
  function automatic logic mdl_mis(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return (addr % 2) != 0;
    if (size >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] mdl_be(input logic [1:0] size, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << (off & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v;
    int off = int'(addr % 4);
    if (size == 2'd0) begin
      v = (rdata >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (rdata >> (8 * (off & 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic run_access(input logic rd, input logic wr, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int delay, input logic exp_mis,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rd);
    int busy;
    logic tmo;
    @(negedge clk);
    i_mem_read = rd; i_mem_write = wr; i_mem_size = size; i_mem_unsigned = uns;
    i_addr = addr; i_write_data = wd; i_dmem_ready = 1'b0;
    #1;
    chk("misaligned", 32'(o_misaligned), 32'(exp_mis));
    chk("stall_idle", 32'(o_stall), 32'(!exp_mis));
    chk("req_idle", 32'(o_dmem_req), 32'd0);
    if (exp_mis) begin
      repeat (2) begin
        @(negedge clk);
        chk("mis_req", 32'(o_dmem_req), 32'd0);
        chk("mis_stall", 32'(o_stall), 32'd0);
      end
    end else begin
      busy = 0;
      tmo = (delay >= TO);
      forever begin
        @(negedge clk);
        if (!o_dmem_req) break;
        busy++;
        if (busy > TO + 1) begin
          chk("busy_bound", 32'(busy), 32'(TO));
          break;
        end
        chk("stall_busy", 32'(o_stall), 32'd1);
        chk("dmem_addr", o_dmem_addr, {addr[31:2], 2'b00});
        chk("dmem_we", 32'(o_dmem_we), 32'(wr));
        if (wr) begin
          chk("dmem_be", 32'(o_dmem_be), 32'(exp_be));
          chk("dmem_wdata", o_dmem_wdata, exp_wdata);
        end
        i_write_data = $urandom;
        if (!tmo && busy - 1 == delay) begin
          i_dmem_ready = 1'b1;
          i_dmem_rdata = rdata;
        end else begin
          i_dmem_ready = 1'b0;
          i_dmem_rdata = $urandom;
        end
      end
      chk("busy_cycles", 32'(busy), tmo ? 32'(TO) : 32'(delay + 1));
      chk("stall_done", 32'(o_stall), 32'd0);
      chk("bus_error", 32'(o_bus_error), 32'(tmo));
    end
    chk("read_data", o_mem_read_data, exp_rd);
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_dmem_ready = 1'b0;
    @(negedge clk);
    chk("bus_error_idle", 32'(o_bus_error), 32'd0);
    chk("req_after", 32'(o_dmem_req), 32'd0);
    chk("read_data_hold", o_mem_read_data, exp_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 1, 1'b0, 4'h0, 32'h0, 32'hFFFFFF80};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1'b0, 4'h0, 32'h0, 32'h00000080};
    tbl[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 0, 1'b0, 4'hC, 32'hABCDABCD, 32'h00000080};
    tbl[4]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h00000080};
    tbl[5]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80017FFF, 2, 1'b0, 4'h0, 32'h0, 32'hFFFF8001};
    tbl[6]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h301, 32'h000000A5, 32'h0, 0, 1'b0, 4'h2, 32'hA5A5A5A5, 32'hFFFF8001};
    tbl[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h203, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'hFFFF8001};
    tbl[8]  = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h400, 32'h11223344, 32'h0, 3, 1'b0, 4'hF, 32'h11223344, 32'hFFFF8001};
    tbl[9]  = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h500, 32'h55AA55AA, 32'h99999999, 0, 1'b0, 4'hF, 32'h55AA55AA, 32'hFFFF8001};
    tbl[10] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h700, 32'h0, 32'h12345678, TO, 1'b0, 4'h0, 32'h0, 32'h00000000};
    tbl[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h704, 32'h0, 32'hCAFEF00D, TO - 1, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D};

    reset = 1'b1;
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_size = 2'b00; i_mem_unsigned = 1'b0;
    i_addr = '0; i_write_data = '0; i_dmem_ready = 1'b0; i_dmem_rdata = '0;
    #1;
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_we", 32'(o_dmem_we), 32'd0);
    chk("rst_addr", o_dmem_addr, 32'd0);
    chk("rst_wdata", o_dmem_wdata, 32'd0);
    chk("rst_be", 32'(o_dmem_be), 32'd0);
    chk("rst_read_data", o_mem_read_data, 32'd0);
    chk("rst_bus_error", 32'(o_bus_error), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_access(tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wd,
                 tbl[i].rdata, tbl[i].delay, tbl[i].mis, tbl[i].be, tbl[i].wdata, tbl[i].rdv);
      model_rd = tbl[i].rdv;
    end

    for (int n = 0; n < 40; n++) begin
      logic        rd, wr, uns, mis;
      logic [1:0]  size;
      logic [31:0] addr, wd, rdata;
      int          r, delay;
      r = int'($urandom_range(0, 2));
      rd = (r != 1); wr = (r != 0);
      size = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      addr = $urandom; wd = $urandom; rdata = $urandom;
      r = int'($urandom_range(0, 9));
      delay = (r < 7) ? r % 3 : ((r == 7) ? TO - 1 : TO);
      mis = mdl_mis(size, addr);
      if (!mis && !wr)
        model_rd = (delay >= TO) ? 32'd0 : mdl_load(size, uns, addr, rdata);
      run_access(rd, wr, size, uns, addr, wd, rdata, delay, mis,
                 mdl_be(size, addr), mdl_wdata(size, wd), model_rd);
    end

    // Reset in the middle of a BUSY access drops the request at once.
    @(negedge clk);
    i_mem_read = 1'b1; i_mem_size = 2'b10; i_addr = 32'h600; i_dmem_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_req", 32'(o_dmem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req", 32'(o_dmem_req), 32'd0);
    chk("async_rst_addr", o_dmem_addr, 32'd0);
    chk("async_rst_read_data", o_mem_read_data, 32'd0);
    chk("async_rst_bus_error", 32'(o_bus_error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    i_mem_read = 1'b0; i_dmem_ready = 1'b1; i_dmem_rdata = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_req", 32'(o_dmem_req), 32'd0);
      chk("post_rst_read_data", o_mem_read_data, 32'd0);
      chk("post_rst_bus_error", 32'(o_bus_error), 32'd0);
    end
    i_dmem_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
